// File: rtl/fetch_buffer.sv
// fetch_buffer: IF stage issuing imem reads and buffering {pc, instr} for decode.
// Define FETCH_PERF_EN to add saturating stall/flush performance counters.
module fetch_buffer #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 8,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_W-1:0]    pc_in,
   input  logic               flush,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               imem_en,
   output logic [PC_W-1:0]    imem_addr,
   output logic               fetch_stall,
   output logic               id_valid,
   output logic [PC_W-1:0]    id_pc,
   output logic [INSTR_W-1:0] id_instr,
   input  logic               id_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        perf_stall_cnt,
   output logic [15:0]        perf_flush_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]    pc_mem_q  [DEPTH];
   logic [INSTR_W-1:0] ins_mem_q [DEPTH];

   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            inflight_q, inflight_d;
   logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

   logic [CW:0] used;
   logic        issue;
   logic        push;
   logic        pop;

   // Credits cover both buffered entries and the read still in flight.
   assign used  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue = !flush && (used < (CW+1)'(DEPTH));
   assign push  = inflight_q && !flush;
   assign pop   = id_valid && id_ready && !flush;

   assign imem_en     = rst && issue;
   assign imem_addr   = pc_in;
   assign fetch_stall = rst && !issue;

   assign id_valid = (count_q != '0);
   assign id_pc    = pc_mem_q[rd_ptr_q];
   assign id_instr = ins_mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      if (flush) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         inflight_d = issue;
         if (issue) inflight_pc_d = pc_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Storage is cleared too so the head is never X after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]  <= '0;
            ins_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]  <= inflight_pc_q;
         ins_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!issue && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      (push && !pop) |-> (count_q < CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer with a synchronous imem.
// Entries are queued as fetches are issued and compared as decode pops them.
module tb_fetch_buffer;

   localparam int DEPTH   = 4;
   localparam int PC_W    = 8;
   localparam int INSTR_W = 32;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } ent_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [PC_W-1:0]    pc_in = '0;
   logic               flush = 1'b0;
   logic [INSTR_W-1:0] imem_rdata = '0;
   logic               imem_en;
   logic [PC_W-1:0]    imem_addr;
   logic               fetch_stall;
   logic               id_valid;
   logic [PC_W-1:0]    id_pc;
   logic [INSTR_W-1:0] id_instr;
   logic               id_ready = 1'b0;
`ifdef FETCH_PERF_EN
   logic [15:0]        perf_stall_cnt;
   logic [15:0]        perf_flush_cnt;
`endif

   int errors = 0;
   int checks = 0;

   ent_t            exp_q[$];
   logic [PC_W-1:0] got_q[$];
   logic            m_inf = 1'b0;
   logic [PC_W-1:0] m_inf_pc = '0;
   logic [PC_W-1:0] pc = '0;
   int              m_stall = 0;
   int              m_flush = 0;
   int              n_issue = 0;
   int              n_stall_obs = 0;

   fetch_buffer #(
      .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pc_in(pc_in),
      .flush(flush),
      .imem_rdata(imem_rdata),
      .imem_en(imem_en),
      .imem_addr(imem_addr),
      .fetch_stall(fetch_stall),
      .id_valid(id_valid),
      .id_pc(id_pc),
      .id_instr(id_instr),
      .id_ready(id_ready)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: word = 0x1000_0000 + address.
   always @(posedge clk)
      if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);

   task automatic step(input logic fl, input logic rdy);
      logic exp_en;
      logic exp_valid;
      logic pop;
      logic push;
      ent_t e;
      flush    = fl;
      id_ready = rdy;
      pc_in    = pc;
      #1;
      exp_en    = !fl && ((exp_q.size() + int'(m_inf)) < DEPTH);
      exp_valid = (exp_q.size() != 0);
      checks++;
      if (imem_en !== exp_en) begin
         errors++;
         $display("FAIL imem_en pc=%h got %b exp %b", pc, imem_en, exp_en);
      end
      checks++;
      if (fetch_stall !== !exp_en) begin
         errors++;
         $display("FAIL fetch_stall pc=%h got %b exp %b", pc, fetch_stall, !exp_en);
      end
      checks++;
      if (imem_addr !== pc) begin
         errors++;
         $display("FAIL imem_addr got %h exp %h", imem_addr, pc);
      end
      checks++;
      if (id_valid !== exp_valid) begin
         errors++;
         $display("FAIL id_valid pc=%h got %b exp %b", pc, id_valid, exp_valid);
      end
      if (exp_valid) begin
         checks++;
         if ({id_pc, id_instr} !== exp_q[0]) begin
            errors++;
            $display("FAIL id_entry got %h/%h exp %h/%h",
                     id_pc, id_instr, exp_q[0].pc, exp_q[0].instr);
         end
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_stall_cnt !== 16'(m_stall)) begin
         errors++;
         $display("FAIL perf_stall got %0d exp %0d", perf_stall_cnt, m_stall);
      end
      checks++;
      if (perf_flush_cnt !== 16'(m_flush)) begin
         errors++;
         $display("FAIL perf_flush got %0d exp %0d", perf_flush_cnt, m_flush);
      end
`endif
      if (imem_en === 1'b1) n_issue++;
      if (fetch_stall === 1'b1) n_stall_obs++;
      pop  = exp_valid && rdy && !fl;
      push = m_inf && !fl;
      if (!exp_en) m_stall++;
      if (fl) m_flush++;
      if (fl) begin
         exp_q.delete();
         m_inf = 1'b0;
      end else begin
         if (pop) begin
            got_q.push_back(id_pc);
            void'(exp_q.pop_front());
         end
         if (push) begin
            e.pc    = m_inf_pc;
            e.instr = 32'h1000_0000 + 32'(m_inf_pc);
            exp_q.push_back(e);
         end
         m_inf = exp_en;
         if (exp_en) begin
            m_inf_pc = pc;
            pc       = pc + 8'd1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      flush    = 1'b0;
      id_ready = 1'b0;
      #1;
      checks++;
      if (id_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_id_valid got %b exp 0", id_valid);
      end
      checks++;
      if (imem_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_imem_en got %b exp 0", imem_en);
      end
      checks++;
      if (fetch_stall !== 1'b0) begin
         errors++;
         $display("FAIL rst_fetch_stall got %b exp 0", fetch_stall);
      end
      checks++;
      if (id_pc !== '0 || id_instr !== '0) begin
         errors++;
         $display("FAIL rst_id_data got %h/%h exp 0/0", id_pc, id_instr);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
      end
`endif
      exp_q.delete();
      got_q.delete();
      m_inf       = 1'b0;
      m_inf_pc    = '0;
      m_stall     = 0;
      m_flush     = 0;
      n_issue     = 0;
      n_stall_obs = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_stream();
      test_reset();
      pc = 8'h00;
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
      checks++;
      if (got_q.size() != 10) begin
         errors++;
         $display("FAIL stream_count got %0d exp 10", got_q.size());
      end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== 8'(k)) begin
            errors++;
            $display("FAIL stream_order[%0d] got %h exp %h", k, got_q[k], 8'(k));
         end
      end
      checks++;
      if (n_stall_obs != 0) begin
         errors++;
         $display("FAIL stream_stalls got %0d exp 0", n_stall_obs);
      end
   endtask

   task automatic test_full();
      test_reset();
      pc = 8'h00;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
      checks++;
      if (n_issue != 4) begin
         errors++;
         $display("FAIL full_issues got %0d exp 4", n_issue);
      end
      step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      checks++;
      if (n_issue != 5) begin
         errors++;
         $display("FAIL full_refill got %0d exp 5", n_issue);
      end
      checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h00) begin
         errors++;
         $display("FAIL full_pop got %0d entries exp 1 (pc 00)", got_q.size());
      end
      checks++;
      if (n_stall_obs != 7) begin
         errors++;
         $display("FAIL full_stalls got %0d exp 7", n_stall_obs);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_stall_cnt !== 16'd7) begin
         errors++;
         $display("FAIL full_perf got %0d exp 7", perf_stall_cnt);
      end
`endif
   endtask

   task automatic test_flush();
      test_reset();
      pc = 8'h00;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      got_q.delete();
      pc = 8'h40;
      step(1'b1, 1'b0);
      checks++;
      if (id_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_valid got %b exp 0", id_valid);
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      checks++;
      if (got_q.size() != 4) begin
         errors++;
         $display("FAIL flush_count got %0d exp 4", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== 8'h40) begin
            errors++;
            $display("FAIL flush_target got %h exp 40", got_q[0]);
         end
      end
   endtask

   task automatic test_flush_pop();
      test_reset();
      pc = 8'h00;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      got_q.delete();
      pc = 8'h80;
      step(1'b1, 1'b1);
      checks++;
      if (id_valid !== 1'b0) begin
         errors++;
         $display("FAIL flushpop_valid got %b exp 0", id_valid);
      end
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL flushpop_popped got %0d exp 0", got_q.size());
      end
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      checks++;
      if (got_q.size() != 6) begin
         errors++;
         $display("FAIL flushpop_count got %0d exp 6", got_q.size());
      end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== 8'h80 + 8'(k)) begin
            errors++;
            $display("FAIL flushpop_pc[%0d] got %h exp %h", k, got_q[k], 8'h80 + 8'(k));
         end
      end
   endtask

   task automatic test_wrap();
      logic [PC_W-1:0] want [3];
      want[0] = 8'hFE;
      want[1] = 8'hFF;
      want[2] = 8'h00;
      test_reset();
      pc = 8'hFE;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      checks++;
      if (got_q.size() < 3) begin
         errors++;
         $display("FAIL wrap_count got %0d exp >=3", got_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_q[k] !== want[k]) begin
               errors++;
               $display("FAIL wrap_pc[%0d] got %h exp %h", k, got_q[k], want[k]);
            end
         end
      end
   endtask

   task automatic test_midreset();
      test_reset();
      pc = 8'h00;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      checks++;
      if (id_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre_valid got %b exp 1", id_valid);
      end
      test_reset();
      pc = 8'h20;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      checks++;
      if (got_q.size() != 4) begin
         errors++;
         $display("FAIL midrst_count got %0d exp 4", got_q.size());
      end
      for (int k = 0; k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== 8'h20 + 8'(k)) begin
            errors++;
            $display("FAIL midrst_pc[%0d] got %h exp %h", k, got_q[k], 8'h20 + 8'(k));
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_stream();
      test_full();
      test_flush();
      test_flush_pop();
      test_wrap();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues a read to the synchronous instruction memory, and captures each returned word with its PC in a small FIFO.
- Presents {pc, instr} pairs to the IF/ID decode side over a valid/ready handshake.
- Provides backpressure to the PC (fetch_stall) and squashes wrong-path fetches on a jump.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- PC_W, 8: PC / instruction-memory address width.
- INSTR_W, 32: instruction word width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- pc_in  input  PC_W  current PC from the PC register.
- flush  input  1  jump taken this cycle (JumpPC); kills all buffered and in-flight fetches.
- imem_rdata  input  INSTR_W  instruction memory read data; valid the cycle after imem_en.
- imem_en  output  1  read request this cycle.
- imem_addr  output  PC_W  read address; equals pc_in.
- fetch_stall  output  1  PC must hold; high whenever imem_en is low and rst is high.
- id_valid  output  1  head entry valid.
- id_pc  output  PC_W  PC of head entry.
- id_instr  output  INSTR_W  instruction of head entry.
- id_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - count, read/write pointers, inflight and inflight_pc are cleared.
  - id_valid, id_pc, id_instr and imem_en are 0; fetch_stall is 0.
  - Release is synchronous to clk.
- Issue:
  - imem_en = !flush && (count + inflight < DEPTH).
  - imem_addr = pc_in, combinational.
  - On issue, inflight <= 1 and inflight_pc <= pc_in.
  - With no issue and no flush, inflight <= 0.
- Response:
  - When inflight = 1 and no flush, the FIFO is written at the end of the cycle with {inflight_pc, imem_rdata}.
  - Because of the credit check, a write never overflows the FIFO.
- Latency:
  - PC issued in cycle N; data returns in cycle N+1.
  - The entry is visible on id_* in cycle N+2 if the FIFO was empty.
  - Sustained throughput: 1 instruction per cycle while id_ready = 1.
- Pop:
  - Occurs when id_valid && id_ready.
  - Head advances; the new head is visible the next cycle.
  - Push and pop in the same cycle keep count unchanged.
- Outputs:
  - id_valid = (count != 0).
  - id_pc / id_instr are driven from the registered head entry.
  - id_pc / id_instr are don't-care when id_valid = 0, but must not be X after reset.
- Flush:
  - On the flush edge: count <= 0, pointers <= 0, inflight <= 0.
  - The in-flight response returning next cycle is discarded.
  - id_valid is 0 in cycle F+1.
  - No issue occurs in cycle F. The first target fetch issues in F+1 at the new pc_in.
  - flush has priority over simultaneous push, pop or issue.
- Full: count + inflight = DEPTH -> imem_en = 0 and fetch_stall = 1 until a pop frees a credit. The freed credit is usable the cycle after the pop.
- PC wrap: pc 8'hFF followed by 8'h00 is stored unchanged. There is no special handling.
- Mid-operation reset: all contents are dropped immediately, with no partial-state retention.
- id_ready while id_valid = 0 is ignored.

Optional Feature:
- FETCH_PERF_EN: when defined, adds two outputs:
  - perf_stall_cnt [15:0]: increments each cycle fetch_stall = 1.
  - perf_flush_cnt [15:0]: increments each cycle flush = 1.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset, then release with id_ready = 1 and pc_in stepping 0,1,2… with imem_rdata = 32'h1000_0000 + addr -> id_valid rises 2 cycles after first issue; id_pc = 0,1,2…; id_instr = 32'h1000_0000, 32'h1000_0001…; one entry per cycle; fetch_stall = 0.
- id_ready = 0 from start, DEPTH = 4 -> exactly 4 issues (pc 0–3); fetch_stall = 1 from the cycle count + inflight = 4. Set id_ready = 1 for one cycle -> pc 0 popped; one new issue at pc 4 the next cycle.
- Flush while FIFO holds pc 3,4 and pc 5 is in flight, pc_in jumps to 8'h40 -> next cycle id_valid = 0; the pc 5 response is dropped; the next delivered entry has id_pc = 8'h40.
- Flush in the same cycle as pop and a returning response -> count = 0 after the edge; no entry from before the flush ever appears on id_*.
- pc_in sequence 8'hFE, 8'hFF, 8'h00 -> delivered id_pc = FE, FF, 00 in order.
- Assert rst low mid-stream with 3 entries buffered -> id_valid = 0 and imem_en = 0 immediately; after release, fetching restarts cleanly. With FETCH_PERF_EN, counters read 0 after reset and perf_stall_cnt equals the number of stalled cycles in the full-FIFO scenario.
